// File: rtl/buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buf_pkg
// Purpose  : Sample-buffer geometry and readout sequencer state encoding.
// Revision : 1.0  initial release
// ============================================================================
package buf_pkg;

  localparam int BUF_ADDR_WIDTH = 13;
  localparam int BUF_DATA_WIDTH = 8;
  localparam int BUF_DEPTH      = 1 << BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/buffer_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : buffer_reader_fifo
// Purpose  : Small synchronous skid FIFO; head is valid whenever occupancy != 0.
// Revision : 1.0  initial release
// ============================================================================
module buffer_reader_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_pop;

  assign do_pop = pop_i && (occ_q != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage is deliberately not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : buffer_reader
// Purpose  : Ring-order readout of the sample buffer onto a valid/ready byte
//            stream. Optional checksum enabled by macro BUF_READER_CSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
module buffer_reader
  import buf_pkg::*;
#(
  parameter int ADDR_WIDTH = BUF_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] buf_addra,
  output logic                  buf_wea,
  input  logic [DATA_WIDTH-1:0] buf_doa,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] csum
);

  localparam int                OCC_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic                  done_q, done_d;
  logic                  vld1_q, vld2_q;
  logic                  issue;
  logic [ADDR_WIDTH:0]   count_clamped;
  logic [1:0]            inflight;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        credit_used;
  logic                  credit_ok;
  logic                  pop;

  assign count_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
  assign inflight      = {1'b0, vld1_q} + {1'b0, vld2_q};
  assign credit_used   = {1'b0, occ} + (OCC_W + 1)'(inflight);
  assign credit_ok     = credit_used < (OCC_W + 1)'(FIFO_DEPTH);

  // Accepting a start also issues the first read, giving first data two edges later.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    addra_d     = addra_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            issue       = 1'b1;
            addra_d     = start_addr;
            addr_d      = start_addr + ADDR_WIDTH'(1);
            remaining_d = count_clamped - (ADDR_WIDTH + 1)'(1);
            state_d     = (count_clamped == (ADDR_WIDTH + 1)'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          issue       = 1'b1;
          addra_d     = addr_q;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == '0 && inflight == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      addra_q     <= '0;
      done_q      <= 1'b0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      addra_q     <= addra_d;
      done_q      <= done_d;
      vld1_q      <= issue;
      vld2_q      <= vld1_q;
    end
  end

  buffer_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clka),
    .rst_i       (rsta),
    .push_i      (vld2_q),
    .push_data_i (buf_doa),
    .pop_i       (pop),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign buf_addra = addra_q;
  assign buf_wea   = 1'b0;

`ifdef BUF_READER_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + m_data;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_reader
// Purpose  : Directed vector bench for buffer_reader against a 1-cycle buffer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_buffer_reader;
  import buf_pkg::*;

  logic        clka = 1'b0;
  logic        rsta;
  logic        start;
  logic [12:0] start_addr;
  logic [13:0] count;
  logic        busy;
  logic        done;
  logic [12:0] buf_addra;
  logic        buf_wea;
  logic [7:0]  buf_doa = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  csum;

  logic [7:0]  mem [BUF_DEPTH];
  int          n_checks = 0;
  int          n_err    = 0;

  typedef struct {
    logic [12:0] addr;
    logic [13:0] cnt;
    bit          rnd;
    int          restart_at;
    int          exp_len;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[6];

  buffer_reader dut (
    .clka       (clka),
    .rsta       (rsta),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .buf_addra  (buf_addra),
    .buf_wea    (buf_wea),
    .buf_doa    (buf_doa),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .csum       (csum)
  );

  always #5 clka = ~clka;

  always @(posedge clka) buf_doa <= mem[buf_addra];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'(i) ^ 8'hA5;
  endtask

  task automatic run_vec(input vec_t v, input int idx, output logic [7:0] csum_done);
    logic [7:0]  got[$];
    logic [7:0]  stall_data;
    logic [7:0]  exp_csum;
    logic [12:0] ai;
    bit          stall_pend;
    bit          r;
    int          n, budget, first_v, done_cnt, done_early, stall_bad, mism, tail, busy1;
    got = {};
    stall_pend = 1'b0; stall_data = 8'h00; csum_done = 8'h00;
    first_v = -1; done_cnt = 0; done_early = 0; stall_bad = 0; mism = 0; tail = -1; busy1 = 0;
    budget = v.exp_len * (v.rnd ? 8 : 2) + 60;
    @(negedge clka);
    start = 1'b1; start_addr = v.addr; count = v.cnt; m_ready = 1'b0;
    @(negedge clka);
    start = 1'b0;
    n = 0;
    while (n < budget && tail != 0) begin
      n++;
      if (n == 1) busy1 = int'(busy);
      if (m_valid && first_v < 0) first_v = n;
      if (stall_pend && (!m_valid || m_data != stall_data)) stall_bad++;
      if (done) begin
        done_cnt++;
        csum_done = csum;
        if (got.size() != v.exp_len) done_early++;
        if (tail < 0) tail = 3;
      end
      if (n == v.restart_at) begin
        start = 1'b1; start_addr = 13'd500; count = 14'd3;
      end else begin
        start = 1'b0;
      end
      r = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = r;
      if (m_valid && r) got.push_back(m_data);
      stall_pend = m_valid && !r;
      stall_data = m_data;
      if (tail > 0) tail--;
      @(negedge clka);
    end
    m_ready = 1'b0;
    start   = 1'b0;
    exp_csum = 8'h00;
    for (int i = 0; i < got.size(); i++) begin
      ai = v.addr + 13'(i);
      if (got[i] != mem[ai]) mism++;
    end
`ifdef BUF_READER_CSUM_EN
    for (int i = 0; i < v.exp_len; i++) begin
      ai = v.addr + 13'(i);
      exp_csum = exp_csum + mem[ai];
    end
`endif
    check($sformatf("v%0d_completed", idx), (tail == 0) ? 1 : 0, 1);
    check($sformatf("v%0d_busy_at_start", idx), busy1, 1);
    check($sformatf("v%0d_first_valid_cycle", idx), first_v, 3);
    check($sformatf("v%0d_len", idx), got.size(), v.exp_len);
    check($sformatf("v%0d_first_byte", idx), (got.size() > 0) ? int'(got[0]) : -1, int'(v.exp_first));
    check($sformatf("v%0d_last_byte", idx), (got.size() > 0) ? int'(got[got.size()-1]) : -1, int'(v.exp_last));
    check($sformatf("v%0d_data_mismatches", idx), mism, 0);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_done_before_last", idx), done_early, 0);
    check($sformatf("v%0d_stall_unstable", idx), stall_bad, 0);
    check($sformatf("v%0d_busy_after", idx), int'(busy), 0);
    check($sformatf("v%0d_csum", idx), int'(csum_done), int'(exp_csum));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    int nb, n, bad;
    vecs[0] = '{13'd0,    14'd16,   1'b0,  6, 16,   8'hA5, 8'hAA};
    vecs[1] = '{13'd8190, 14'd5,    1'b0, -1, 5,    8'h5B, 8'hA7};
    vecs[2] = '{13'd0,    14'd8192, 1'b1, -1, 8192, 8'hA5, 8'h5A};
    vecs[3] = '{13'd100,  14'd9000, 1'b0, -1, 8192, 8'hC1, 8'hC6};
    vecs[4] = '{13'd8191, 14'd1,    1'b0, -1, 1,    8'h5A, 8'h5A};
    vecs[5] = '{13'd5,    14'd3,    1'b1, -1, 3,    8'hA0, 8'hA2};
    init_mem();
    rsta = 1'b1; start = 1'b0; start_addr = '0; count = '0; m_ready = 1'b0;
    repeat (3) @(negedge clka);
    rsta = 1'b0;
    @(negedge clka);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_buf_addra", int'(buf_addra), 0);
    check("reset_buf_wea", int'(buf_wea), 0);
    check("reset_csum", int'(csum), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i, cs);

    // count == 0: done one cycle later, no data, never busy
    start = 1'b1; start_addr = 13'd77; count = 14'd0;
    @(negedge clka);
    start = 1'b0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_valid", int'(m_valid), 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka);
      if (done || busy || m_valid) bad++;
    end
    check("zero_quiet_after", bad, 0);

    // reset after 10 of 100 bytes aborts the run
    start = 1'b1; start_addr = 13'd0; count = 14'd100; m_ready = 1'b1;
    @(negedge clka);
    start = 1'b0; nb = 0; n = 0;
    while (nb < 10 && n < 200) begin
      n++;
      if (m_valid) nb++;
      if (nb == 10) rsta = 1'b1;
      @(negedge clka);
    end
    check("abort_reached_10", nb, 10);
    check("abort_valid_low", int'(m_valid), 0);
    check("abort_busy_low", int'(busy), 0);
    rsta = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clka);
      if (done || m_valid || busy) bad++;
    end
    check("abort_no_done_no_data", bad, 0);
    m_ready = 1'b0;
    run_vec('{13'd40, 14'd8, 1'b0, -1, 8, 8'h8D, 8'h8A}, 6, cs);

    // checksum run over {1,2,3,FF}
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;
    run_vec('{13'd0, 14'd4, 1'b0, -1, 4, 8'h01, 8'hFF}, 7, cs);
`ifdef BUF_READER_CSUM_EN
    check("csum_at_done", int'(cs), 8'h05);
    repeat (4) @(negedge clka);
    check("csum_held", int'(csum), 8'h05);
`else
    check("csum_tied_zero", int'(cs), 0);
`endif
    init_mem();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
